// File: rtl/nibble_frame_rx_pkg.sv
// nibble_frame_rx_pkg: shared constants, FSM states and the MSB-first frame bit order
package nibble_frame_rx_pkg;
  localparam int NIB_W      = 4;
  localparam int NUM_NIB    = 4;
  localparam int FRAME_BITS = NIB_W * NUM_NIB;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_e;

  // Wire bit k of a frame is f[FRAME_BITS-1-k]: word A first, each word MSB first.
  function automatic logic [NIB_W-1:0] frame_word(input logic [FRAME_BITS-1:0] f, input int i);
    return f[FRAME_BITS-1-i*NIB_W -: NIB_W];
  endfunction
endpackage

// File: rtl/nibble_frame_rx_shreg.sv
// nibble_frame_rx_shreg: frame shift register with running parity, clear and enable
module nibble_frame_rx_shreg
  import nibble_frame_rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  din,
  output logic [FRAME_BITS-1:0] data,
  output logic                  par
);
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  par_q, par_d;

  // Clear takes effect first so clr+en starts a fresh frame with din as bit 0.
  always_comb begin
    data_d = clr ? '0 : data_q;
    par_d  = clr ? 1'b0 : par_q;
    if (en) begin
      data_d = {data_d[FRAME_BITS-2:0], din};
      par_d  = par_d ^ din;
    end
  end

  // Shift register and parity state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      par_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      par_q  <= par_d;
    end
  end

  assign data = data_q;
  assign par  = par_q;
endmodule

// File: rtl/nibble_frame_rx.sv
// nibble_frame_rx: serial four-nibble frame receiver with parity and framing checks
module nibble_frame_rx
  import nibble_frame_rx_pkg::*;
#(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       transmit,
  input  logic       transmit_data,
  output logic [3:0] recevA,
  output logic [3:0] recevB,
  output logic [3:0] recevC,
  output logic [3:0] recevD,
  output logic       received,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] recev_q, recev_d;
  logic                  rcv_q, rcv_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                  shift_en, shift_clr, commit;
  logic [FRAME_BITS-1:0] sh_data, frame_nxt;
  logic                  sh_par;

  nibble_frame_rx_shreg u_shreg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (shift_en),
    .clr  (shift_clr),
    .din  (transmit_data),
    .data (sh_data),
    .par  (sh_par)
  );

  // Without parity the commit happens while bit 15 is still on the wire, so include it.
  assign frame_nxt = PARITY_EN ? sh_data : {sh_data[FRAME_BITS-2:0], transmit_data};

  // Next-state, bit counter, shift control and registered pulse outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_en  = 1'b0;
    shift_clr = 1'b0;
    commit    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        shift_clr = 1'b1;
        if (transmit) begin
          shift_en = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (!transmit) begin
          shift_clr = 1'b1;
          ferr_d    = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            cnt_d = '0;
            if (PARITY_EN) state_d = PARITY;
            else begin
              commit  = 1'b1;
              state_d = GAP;
            end
          end
        end
      end
      PARITY: begin
        if (!transmit) begin
          shift_clr = 1'b1;
          ferr_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = GAP;
          commit  = (transmit_data == sh_par);
          perr_d  = (transmit_data != sh_par);
        end
      end
      GAP: state_d = transmit ? GAP : IDLE;
      default: state_d = IDLE;
    endcase
    rcv_d   = commit;
    recev_d = commit ? frame_nxt : recev_q;
  end

  // State, counter, holding registers and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      recev_q <= '0;
      rcv_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      recev_q <= recev_d;
      rcv_q   <= rcv_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign recevA     = frame_word(recev_q, 0);
  assign recevB     = frame_word(recev_q, 1);
  assign recevC     = frame_word(recev_q, 2);
  assign recevD     = frame_word(recev_q, 3);
  assign received   = rcv_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q == SHIFT) || (state_q == PARITY);
endmodule

// File: doc/nibble_frame_rx.md
Name: nibble_frame_rx

Overview:
Serial receiver for the four-nibble link. It deserialises one frame of 4 x 4-bit words sent on transmit_data while transmit is high, and checks a trailing even-parity bit. Good frames are committed to the recevA..recevD holding registers with a one-cycle received pulse. It sits at the far end of the serial link, opposite the four-register transmitter, and reports framing and parity faults.

Parameters:
NIB_W, 4, width of each received word.
NUM_NIB, 4, words per frame; fixed at 4 for this port list. Frame data length is NIB_W*NUM_NIB = 16 bits.
PARITY_EN, 1, 1 = one even-parity bit follows the data; 0 = no parity bit and parity_err is never asserted.

Ports:
clk  input  1  single system clock; all logic is rising-edge.
rst_n  input  1  asynchronous active-low reset.
transmit  input  1  frame-valid; high for every bit cycle of a frame.
transmit_data  input  1  serial data; one bit per clk while transmit is high.
recevA  output  4  word A of the last good frame.
recevB  output  4  word B of the last good frame.
recevC  output  4  word C of the last good frame.
recevD  output  4  word D of the last good frame.
received  output  1  one-cycle pulse when a good frame is committed.
parity_err  output  1  one-cycle pulse when the parity check fails.
frame_err  output  1  one-cycle pulse when transmit drops mid-frame.
busy  output  1  high while in SHIFT or PARITY.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, bit counter=0, shift register=0.
  - recevA..D=0; received, parity_err, frame_err, busy=0.
- Bit order: MSB first, A[3] to A[0], then B, C, D; D[0] is data bit 15. Parity bit = XOR of the 16 data bits.
- IDLE:
  - transmit=1 samples bit 0 in that same cycle; count=1; go to SHIFT.
  - transmit=0: remain in IDLE.
- SHIFT:
  - Each cycle with transmit=1 shifts in one bit.
  - When data bit 15 is sampled: go to PARITY if PARITY_EN=1, else commit.
  - transmit=0 before bit 15: abort. frame_err=1 on the next cycle, shift register discarded, recev* unchanged, go to IDLE.
- PARITY:
  - transmit=1: sample the parity bit. Match -> commit; mismatch -> parity_err=1 next cycle, recev* unchanged. Either way go to GAP.
  - transmit=0: abort exactly as in SHIFT.
- Commit:
  - recevA..D load from the shift register.
  - received=1 for exactly one cycle: the cycle after the last frame bit is sampled (latency 1).
  - State goes to GAP.
- GAP:
  - While transmit=1, extra bits are ignored (no error).
  - transmit=0 -> IDLE. A new frame therefore needs at least one low cycle between frames.
- Mutual exclusion: received, parity_err and frame_err never assert in the same cycle.
- busy=1 in SHIFT and PARITY only.
- Reset mid-frame: immediate return to the reset values; a partial frame never reaches recev*.
- recev* hold their values across errors and idle periods, and change only on commit.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SHIFT, PARITY, GAP};
  - constants NIB_W=4, NUM_NIB=4, FRAME_BITS=16;
  - the MSB-first bit-order definition, shared with the transmitter.
- One natural sub-module: nibble_frame_rx_shreg. It contains the 16-bit shift register plus running parity XOR, with enable/clear inputs. The FSM, counter and output registers stay in the top.

Test Plan:
- Good frame A=A,B=5,C=3,D=C, stream 1010 0101 0011 1100 + parity 0 -> received pulse 1 cycle after the parity bit; recevA..D=A,5,3,C; no error flags.
- Same frame with parity bit 1 -> parity_err pulse, received=0, recev* keep the previous values (0 after reset).
- transmit dropped after 9 bits -> frame_err pulse next cycle, busy falls, recev* unchanged. A following full frame F,0,F,0 with parity 0 is received correctly.
- transmit held high for 3 cycles after the parity bit, then a gap, then frame 1,2,4,8 with parity 0 -> no errors, recev*=1,2,4,8, exactly one received pulse per frame.
- rst_n asserted at data bit 7 of a frame -> all outputs 0 immediately. After release, a clean frame 6,9,6,9 with parity 0 is received.
- PARITY_EN=0, frame 3,C,3,C -> received one cycle after data bit 15; parity_err never asserts.
